etapa_wb: RTL
=============

// Module: etapa_WB
// PURPOSE
//  Writeback stage of the vector pipeline: the write-side counterpart of etapa_ID's register read.
//  Accepts results from EX/MEM over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
//  Drains one entry per cycle into the vector or scalar bank via reg_wrv/reg_wrs, i_dir_wr,
//  data_wrv and data_wrs. Exports per-register pending masks so decode can stall on RAW hazards.
// PARAMETERS
//  DEPTH   4   FIFO entries; power of two, >=2
//  ADDR_W  3   register address width (8 vector + 8 scalar regs)
//  VEC_W   32  vector datum width (4 lanes x 8b)
//  SCA_W   8   scalar datum width
// PORTS
//  clk        in   1       pipeline clock
//  rst        in   1       synchronous, active-high reset
//  in_valid   in   1       result present from EX/MEM
//  in_ready   out  1       FIFO can accept; = !full
//  in_is_vec  in   1       1=vector dest, 0=scalar dest
//  in_dir     in   ADDR_W  destination register
//  in_data_v  in   VEC_W   vector result (used when in_is_vec)
//  in_data_s  in   SCA_W   scalar result (used when !in_is_vec)
//  wb_stall   in   1       hold drain this cycle (bank port busy)
//  reg_wrv    out  1       vector bank write strobe
//  reg_wrs    out  1       scalar bank write strobe
//  i_dir_wr   out  ADDR_W  write address to both banks
//  data_wrv   out  VEC_W   vector write data
//  data_wrs   out  SCA_W   scalar write data
//  pend_vec   out  2^ADDR_W bit i=1: some FIFO entry or current write targets vector reg i
//  pend_sca   out  2^ADDR_W same for scalar regs
// BEHAVIOUR
//  - Reset: FIFO empty; in_ready=1; reg_wrv=reg_wrs=0; i_dir_wr=0; data_wrv=0; data_wrs=0; pend_*=0.
//  - Push when in_valid&&in_ready; the unused data field is stored as zero.
//  - Pop when !empty&&!wb_stall; popped entry is registered onto the write outputs next edge.
//    Exactly one of reg_wrv/reg_wrs is high for one cycle per pop, else both 0.
//  - Latency: accepted at edge N, earliest strobe in cycle after edge N+1 (no combinational in->out path).
//  - Strobes deassert on stall/empty; i_dir_wr/data_* hold their last value.
//  - Simultaneous push+pop when full: push refused (in_ready=0 is based on registered count).
//    Push+pop when 1 entry: count stays 1. Pointers wrap modulo DEPTH.
//  - Ordering strictly FIFO; same dest pushed twice is written twice, in order.
//  - pend_*: OR of valid FIFO entries plus the strobed output register; combinational from state.
//  - Reset mid-drain: all entries discarded, no strobe in the cycle after the reset edge.
// CONFIGURATION
//  WB_FWD_EN defined: adds ports fwd_is_vec(in,1), fwd_dir(in,ADDR_W), fwd_hit(out,1),
//   fwd_data_v(out,VEC_W) and fwd_data_s(out,SCA_W).
//   The youngest matching entry (FIFO or output reg, same type+dir) drives the data
//   combinationally with fwd_hit=1; fwd_data_* are 0 on a miss.
//  Undefined: no forwarding ports or logic; decode relies on pend_* to stall.
// STRUCTURE
//  Shared package vp_pkg: ADDR_W/VEC_W/SCA_W constants, wb_entry_t {is_vec, dir, data_v, data_s}.
//  One sub-module: wb_fifo (DEPTH x wb_entry_t storage, pointers, count, full/empty, entry-valid vector).
//  etapa_WB contains the drain/output register, pending-mask decode and optional forward mux.
// TESTING
//  1 Reset then push vec dir=5 data=0xDEADBEEF -> reg_wrv=1, i_dir_wr=5, data_wrv=0xDEADBEEF
//    exactly 2 cycles after push; pend_vec[5] high until the strobe cycle ends.
//  2 Push 4 scalars (dirs 0-3, data 0x11-0x44) with wb_stall=1 -> in_ready=0 after 4th;
//    a 5th push is refused. Release stall -> 4 reg_wrs strobes in order 0x11..0x44.
//  3 Full FIFO with push+pop same cycle -> push refused; count ends at 3; no data lost/duplicated.
//  4 Alternate vec/sca pushes to dir 2 -> reg_wrv/reg_wrs alternate; pend_vec[2] and pend_sca[2]
//    tracked independently.
//  5 Assert rst with 3 entries queued -> no strobe after reset; pend_*=0; in_ready=1.
//  6 WB_FWD_EN: queue vec dir=1 0xA, then 0xB; query fwd_dir=1,vec -> fwd_hit=1, data 0xB;
//    query scalar dir=1 -> fwd_hit=0.

Source files
------------

// File: rtl/etapa_wb_pkg.sv
// Shared widths and writeback entry types for the vector pipeline writeback stage.
// Optional forwarding is enabled across the slice by defining WB_FWD_EN.
package etapa_wb_pkg;

    localparam int ADDR_W = 3;
    localparam int VEC_W  = 32;
    localparam int SCA_W  = 8;
    localparam int NREG   = 1 << ADDR_W;

    typedef struct packed {
        logic              is_vec;
        logic [ADDR_W-1:0] dir;
        logic [VEC_W-1:0]  data_v;
        logic [SCA_W-1:0]  data_s;
    } wb_entry_t;

    typedef struct packed {
        logic              is_vec;
        logic [ADDR_W-1:0] dir;
    } wb_tag_t;

    // The data field that does not belong to the destination bank is forced to zero.
    function automatic wb_entry_t mk_entry(input logic              is_vec,
                                           input logic [ADDR_W-1:0] dir,
                                           input logic [VEC_W-1:0]  data_v,
                                           input logic [SCA_W-1:0]  data_s);
        wb_entry_t e;
        e.is_vec = is_vec;
        e.dir    = dir;
        e.data_v = is_vec ? data_v : '0;
        e.data_s = is_vec ? '0 : data_s;
        return e;
    endfunction

endpackage

// File: rtl/etapa_wb_if.sv
// Writeback stage bus: EX/MEM result handshake, bank write port, pending masks.
// Forward query/response signals exist only when WB_FWD_EN is defined.
interface etapa_wb_if;
    import etapa_wb_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic              in_is_vec;
    logic [ADDR_W-1:0] in_dir;
    logic [VEC_W-1:0]  in_data_v;
    logic [SCA_W-1:0]  in_data_s;
    logic              wb_stall;
    logic              reg_wrv;
    logic              reg_wrs;
    logic [ADDR_W-1:0] i_dir_wr;
    logic [VEC_W-1:0]  data_wrv;
    logic [SCA_W-1:0]  data_wrs;
    logic [NREG-1:0]   pend_vec;
    logic [NREG-1:0]   pend_sca;
`ifdef WB_FWD_EN
    logic              fwd_is_vec;
    logic [ADDR_W-1:0] fwd_dir;
    logic              fwd_hit;
    logic [VEC_W-1:0]  fwd_data_v;
    logic [SCA_W-1:0]  fwd_data_s;
`endif

    modport master (
        output in_valid, in_is_vec, in_dir, in_data_v, in_data_s, wb_stall,
        input  in_ready, reg_wrv, reg_wrs, i_dir_wr, data_wrv, data_wrs, pend_vec, pend_sca
`ifdef WB_FWD_EN
        , output fwd_is_vec, fwd_dir
        , input  fwd_hit, fwd_data_v, fwd_data_s
`endif
    );

    modport slave (
        input  in_valid, in_is_vec, in_dir, in_data_v, in_data_s, wb_stall,
        output in_ready, reg_wrv, reg_wrs, i_dir_wr, data_wrv, data_wrs, pend_vec, pend_sca
`ifdef WB_FWD_EN
        , input  fwd_is_vec, fwd_dir
        , output fwd_hit, fwd_data_v, fwd_data_s
`endif
    );

endinterface

// File: rtl/etapa_wb_fifo.sv
// DEPTH-entry result FIFO; exposes head plus per-entry tags in age order (index 0 = oldest).
// Full/empty come from the registered count; WB_FWD_EN adds per-entry data outputs.
module etapa_wb_fifo
    import etapa_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  wb_entry_t              i_entry,
    output logic                   o_full,
    output logic                   o_empty,
    output wb_entry_t              o_head,
    output logic [DEPTH-1:0]       o_vld,
    output wb_tag_t [DEPTH-1:0]    o_tag
`ifdef WB_FWD_EN
    ,
    output logic [DEPTH-1:0][VEC_W-1:0] o_dv,
    output logic [DEPTH-1:0][SCA_W-1:0] o_ds
`endif
);
    localparam int PW = $clog2(DEPTH);

    wb_entry_t       r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [PW:0]     r_count;
    logic            w_do_push;
    logic            w_do_pop;

    assign o_full    = (r_count == (PW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_entry;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + {{PW{1'b0}}, w_do_push} - {{PW{1'b0}}, w_do_pop};
        end
    end

    // Pointer arithmetic wraps naturally because DEPTH is a power of two.
    always_comb begin
        o_vld = '0;
        o_tag = '0;
`ifdef WB_FWD_EN
        o_dv  = '0;
        o_ds  = '0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            o_vld[k]        = ((PW+1)'(k) < r_count);
            o_tag[k].is_vec = r_mem[r_rd_ptr + PW'(k)].is_vec;
            o_tag[k].dir    = r_mem[r_rd_ptr + PW'(k)].dir;
`ifdef WB_FWD_EN
            o_dv[k]         = r_mem[r_rd_ptr + PW'(k)].data_v;
            o_ds[k]         = r_mem[r_rd_ptr + PW'(k)].data_s;
`endif
        end
    end

endmodule

// File: rtl/etapa_wb.sv
// Writeback stage: FIFO-buffered results drained one per cycle into the vector/scalar banks,
// one registered cycle after the pop; in_ready = !full; pend_* masks for RAW stalls (WB_FWD_EN adds forwarding).
module etapa_wb
    import etapa_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    etapa_wb_if.slave   bus
);
    wb_entry_t            w_entry;
    wb_entry_t            w_head;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic [DEPTH-1:0]     w_vld;
    wb_tag_t [DEPTH-1:0]  w_tag;
    logic [NREG-1:0]      w_pend_vec;
    logic [NREG-1:0]      w_pend_sca;
`ifdef WB_FWD_EN
    logic [DEPTH-1:0][VEC_W-1:0] w_dv;
    logic [DEPTH-1:0][SCA_W-1:0] w_ds;
    logic                        w_fwd_hit;
    logic [VEC_W-1:0]            w_fwd_dv;
    logic [SCA_W-1:0]            w_fwd_ds;
`endif

    logic              r_wrv;
    logic              r_wrs;
    logic [ADDR_W-1:0] r_dir;
    logic [VEC_W-1:0]  r_dv;
    logic [SCA_W-1:0]  r_ds;

    assign w_entry = mk_entry(bus.in_is_vec, bus.in_dir, bus.in_data_v, bus.in_data_s);
    assign w_push  = bus.in_valid && !w_full;
    assign w_pop   = !w_empty && !bus.wb_stall;

    etapa_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_entry (w_entry),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head),
        .o_vld   (w_vld),
        .o_tag   (w_tag)
`ifdef WB_FWD_EN
        ,
        .o_dv    (w_dv),
        .o_ds    (w_ds)
`endif
    );

    // Strobes are single-cycle; address/data hold while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrv <= 1'b0;
            r_wrs <= 1'b0;
            r_dir <= '0;
            r_dv  <= '0;
            r_ds  <= '0;
        end else if (w_pop) begin
            r_wrv <= w_head.is_vec;
            r_wrs <= !w_head.is_vec;
            r_dir <= w_head.dir;
            r_dv  <= w_head.data_v;
            r_ds  <= w_head.data_s;
        end else begin
            r_wrv <= 1'b0;
            r_wrs <= 1'b0;
        end
    end

    always_comb begin
        w_pend_vec = '0;
        w_pend_sca = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (w_vld[k] && w_tag[k].is_vec)  w_pend_vec[w_tag[k].dir] = 1'b1;
            if (w_vld[k] && !w_tag[k].is_vec) w_pend_sca[w_tag[k].dir] = 1'b1;
        end
        if (r_wrv) w_pend_vec[r_dir] = 1'b1;
        if (r_wrs) w_pend_sca[r_dir] = 1'b1;
    end

    assign bus.in_ready = !w_full;
    assign bus.reg_wrv  = r_wrv;
    assign bus.reg_wrs  = r_wrs;
    assign bus.i_dir_wr = r_dir;
    assign bus.data_wrv = r_dv;
    assign bus.data_wrs = r_ds;
    assign bus.pend_vec = w_pend_vec;
    assign bus.pend_sca = w_pend_sca;

`ifdef WB_FWD_EN
    // Output register is the oldest candidate; later (younger) FIFO matches override it.
    always_comb begin
        w_fwd_hit = 1'b0;
        w_fwd_dv  = '0;
        w_fwd_ds  = '0;
        if (((r_wrv && bus.fwd_is_vec) || (r_wrs && !bus.fwd_is_vec)) && (r_dir == bus.fwd_dir)) begin
            w_fwd_hit = 1'b1;
            w_fwd_dv  = r_dv;
            w_fwd_ds  = r_ds;
        end
        for (int k = 0; k < DEPTH; k++) begin
            if (w_vld[k] && (w_tag[k].is_vec == bus.fwd_is_vec) && (w_tag[k].dir == bus.fwd_dir)) begin
                w_fwd_hit = 1'b1;
                w_fwd_dv  = w_dv[k];
                w_fwd_ds  = w_ds[k];
            end
        end
    end

    assign bus.fwd_hit    = w_fwd_hit;
    assign bus.fwd_data_v = w_fwd_dv;
    assign bus.fwd_data_s = w_fwd_ds;
`endif

endmodule
